// File: rtl/spi_tape_sram_target_if.sv
// spi_tape_sram_target_if: SPI pins, host back-door port and busy flag of the tape SRAM target
// master: drives cs_n/sck/mosi and hst_we/hst_addr/hst_wdata, receives miso/miso_oe/hst_rdata/busy
// slave : the target side, directions reversed
interface spi_tape_sram_target_if #(
  parameter int AW = 8
) ();
  logic spi_cs_n, spi_sck, spi_mosi, spi_miso, spi_miso_oe;
  logic hst_we;
  logic [AW-1:0] hst_addr;
  logic [7:0] hst_wdata, hst_rdata;
  logic busy;
  modport master (
    output spi_cs_n, spi_sck, spi_mosi, hst_we, hst_addr, hst_wdata,
    input spi_miso, spi_miso_oe, hst_rdata, busy
  );
  modport slave (
    input spi_cs_n, spi_sck, spi_mosi, hst_we, hst_addr, hst_wdata,
    output spi_miso, spi_miso_oe, hst_rdata, busy
  );
endinterface

// File: rtl/spi_tape_sram_target.sv
// spi_tape_sram_target: SPI mode-0 byte SRAM responder (READ 0x03 / WRITE 0x02, 1-byte address, auto-increment)
// Ports: clk, rst_n (sync, active low), bus (spi_tape_sram_target_if.slave):
//   spi_cs_n/spi_sck/spi_mosi in, spi_miso/spi_miso_oe out, hst_we/hst_addr/hst_wdata in,
//   hst_rdata out (registered back-door read), busy out (synchronized ~cs_n).
// Optional: define SPI_TGT_STATUS_EN to add command 0x05 returning the count of SPI-written bytes.
module spi_tape_sram_target #(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input logic clk,
  input logic rst_n,
  spi_tape_sram_target_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE, STATUS} state_t;
  state_t st, nxt;
  logic [7:0] mem [DEPTH];
  logic [1:0] cs_sy, sck_sy, mosi_sy;
  logic cs_q, sck_q, cs_fall, cs_rise, sck_rise, sck_fall, byte_done;
  logic [2:0] cnt;
  logic [6:0] sh;
  logic [7:0] nb, tx, wr_data, hst_rdata;
  logic [AW-1:0] addr, addr_n;
  logic rd, miso_q, wr_pend, busy_q, oe;
`ifdef SPI_TGT_STATUS_EN
  logic [7:0] wcnt;
`endif
  assign cs_fall = cs_q & ~cs_sy[1];
  assign cs_rise = ~cs_q & cs_sy[1];
  assign sck_rise = ~sck_q & sck_sy[1];
  assign sck_fall = sck_q & ~sck_sy[1];
  assign nb = {sh, mosi_sy[1]};
  assign byte_done = sck_rise & (cnt == 3'd7);
  assign addr_n = addr + 1'b1;
  // cs is seen as already low out of reset, so a cs held low through reset
  // produces no falling edge until it has risen and fallen again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sy <= 2'b00;
      cs_q <= 1'b0;
      sck_sy <= 2'b00;
      sck_q <= 1'b0;
      mosi_sy <= 2'b00;
    end else begin
      cs_sy <= {cs_sy[0], bus.spi_cs_n};
      cs_q <= cs_sy[1];
      sck_sy <= {sck_sy[0], bus.spi_sck};
      sck_q <= sck_sy[1];
      mosi_sy <= {mosi_sy[0], bus.spi_mosi};
    end
  end
  always_ff @(posedge clk) st <= !rst_n ? IDLE : nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = cs_fall ? CMD : IDLE;
      CMD: if (byte_done) nxt = (nb == 8'h03 || nb == 8'h02) ? ADDR : IGNORE;
      ADDR: if (byte_done) nxt = rd ? READ : WRITE;
      default: nxt = st;
    endcase
`ifdef SPI_TGT_STATUS_EN
    if (st == CMD && byte_done && nb == 8'h05) nxt = STATUS;
`endif
    if (cs_rise) nxt = IDLE;
  end
  always_comb begin
    oe = st == READ;
`ifdef SPI_TGT_STATUS_EN
    oe = oe | (st == STATUS);
`endif
  end
  assign bus.spi_miso_oe = oe;
  assign bus.spi_miso = oe & miso_q;
  assign bus.hst_rdata = hst_rdata;
  assign bus.busy = busy_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      sh <= '0;
      rd <= 1'b0;
      addr <= '0;
      tx <= '0;
      miso_q <= 1'b0;
      wr_pend <= 1'b0;
      wr_data <= '0;
      hst_rdata <= '0;
      busy_q <= 1'b0;
`ifdef SPI_TGT_STATUS_EN
      wcnt <= '0;
`endif
    end else begin
      hst_rdata <= mem[bus.hst_addr];
      busy_q <= ~cs_sy[1];
      cnt <= cs_fall ? 3'd0 : sck_rise ? cnt + 3'd1 : cnt;
      if (sck_rise) sh <= nb[6:0];
      if (st == CMD && byte_done) rd <= nb == 8'h03;
      // a completed write byte commits next cycle even if cs rises meanwhile
      wr_pend <= st == WRITE && byte_done;
      if (st == WRITE && byte_done) wr_data <= nb;
      if (wr_pend) addr <= addr_n;
      if (st == ADDR && byte_done) begin
        addr <= nb[AW-1:0];
        tx <= mem[nb[AW-1:0]];
        miso_q <= 1'b0;
      end
      // the next byte is fetched on the 8th rising edge, ahead of its first falling edge
      if (st == READ && byte_done) begin
        addr <= addr_n;
        tx <= mem[addr_n];
      end
      if ((st == READ || st == STATUS) && sck_fall) begin
        miso_q <= tx[7];
        tx <= {tx[6:0], 1'b0};
      end
`ifdef SPI_TGT_STATUS_EN
      if ((st == CMD && byte_done && nb == 8'h05) || (st == STATUS && byte_done)) tx <= wcnt;
      if (wr_pend) wcnt <= wcnt + 8'd1;
`endif
    end
  end
  // two write ports; the SPI write is issued last so it wins on an address clash
  always_ff @(posedge clk) begin
    if (bus.hst_we) mem[bus.hst_addr] <= bus.hst_wdata;
    if (wr_pend) mem[addr] <= wr_data;
  end
endmodule

// File: tb/tb_spi_tape_sram_target.sv
// tb_spi_tape_sram_target: directed table, corner sequences and randomized transactions against a byte-level model
module tb_spi_tape_sram_target;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_tape_sram_target_if #(.AW(8)) bus ();
  spi_tape_sram_target #(.DEPTH(256), .AW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    string nm;
    logic [0:4][7:0] b;
    int n;
    logic [0:4][7:0] rx;
    logic [0:4][7:0] oe;
  } vec_t;
  vec_t tbl[5];
  int checks = 0;
  int failures = 0;
  int wcount = 0;
  logic [7:0] mm [256];
  logic [7:0] tx_b [8];
  logic [7:0] rx_b [8];
  logic [7:0] oe_b [8];
  logic [7:0] bz_b [8];
  logic [7:0] exp_rx [8];
  logic [7:0] exp_oe [8];
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic hw(input logic [7:0] a, input logic [7:0] d);
    bus.hst_addr = a;
    bus.hst_wdata = d;
    bus.hst_we = 1'b1;
    tick(1);
    bus.hst_we = 1'b0;
    mm[a] = d;
  endtask
  task automatic chkmem(input string nm, input logic [7:0] a, input logic [7:0] e);
    bus.hst_addr = a;
    tick(1);
    chk(nm, bus.hst_rdata, e);
  endtask
  // sends the top nb bits of b MSB first; samples miso/oe/busy at each rising edge
  task automatic sbits(input logic [7:0] b, input int nb, output logic [7:0] rx, output logic [7:0] oe, output logic [7:0] bz);
    rx = '0;
    oe = '0;
    bz = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      bus.spi_mosi = b[i];
      tick(4);
      bus.spi_sck = 1'b1;
      rx[i] = bus.spi_miso;
      oe[i] = bus.spi_miso_oe;
      bz[i] = bus.busy;
      tick(4);
      bus.spi_sck = 1'b0;
    end
  endtask
  task automatic xfer(input int n);
    bus.spi_cs_n = 1'b0;
    tick(4);
    for (int j = 0; j < n; j++) sbits(tx_b[j], 8, rx_b[j], oe_b[j], bz_b[j]);
    tick(4);
    bus.spi_cs_n = 1'b1;
    tick(8);
  endtask
  // byte-level view of one transaction: what comes back on miso and what lands in memory
  task automatic model(input int n);
    logic [7:0] a;
    a = tx_b[1];
    for (int j = 0; j < 8; j++) begin
      exp_rx[j] = 8'h00;
      exp_oe[j] = 8'h00;
    end
    if (n >= 2 && tx_b[0] == 8'h03)
      for (int j = 2; j < n; j++) begin
        exp_rx[j] = mm[a];
        exp_oe[j] = 8'hFF;
        a++;
      end
    if (n >= 2 && tx_b[0] == 8'h02)
      for (int j = 2; j < n; j++) begin
        mm[a] = tx_b[j];
        a++;
        wcount++;
      end
`ifdef SPI_TGT_STATUS_EN
    if (tx_b[0] == 8'h05)
      for (int j = 1; j < n; j++) begin
        exp_rx[j] = 8'(wcount);
        exp_oe[j] = 8'hFF;
      end
`endif
  endtask
  task automatic run_vec(input string nm, input int n);
    model(n);
    xfer(n);
    for (int j = 0; j < n; j++) begin
      chk({nm, "_miso"}, rx_b[j], exp_rx[j]);
      chk({nm, "_oe"}, oe_b[j], exp_oe[j]);
      chk({nm, "_busy"}, bz_b[j], 8'hFF);
    end
  endtask
  // SPI write of sd to sa whose commit cycle coincides with a host write of hd to ha
  task automatic collide(input logic [7:0] sa, input logic [7:0] sd, input logic [7:0] ha, input logic [7:0] hd);
    logic [7:0] r, o, z;
    bus.spi_cs_n = 1'b0;
    tick(4);
    sbits(8'h02, 8, r, o, z);
    sbits(sa, 8, r, o, z);
    sbits(sd, 7, r, o, z);
    bus.spi_mosi = sd[0];
    tick(4);
    bus.spi_sck = 1'b1;
    tick(3);
    bus.hst_addr = ha;
    bus.hst_wdata = hd;
    bus.hst_we = 1'b1;
    tick(1);
    bus.hst_we = 1'b0;
    bus.spi_sck = 1'b0;
    tick(4);
    bus.spi_cs_n = 1'b1;
    tick(8);
    mm[ha] = hd;
    mm[sa] = sd;
    wcount++;
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] r, o, z;
    int n, k;
    tbl[0] = '{nm: "rd10", b: 40'h03_10_00_00_00, n: 3, rx: 40'h00_00_A5_00_00, oe: 40'h00_00_FF_00_00};
    tbl[1] = '{nm: "wrFE", b: 40'h02_FE_11_22_33, n: 5, rx: 40'h0, oe: 40'h0};
`ifdef SPI_TGT_STATUS_EN
    tbl[2] = '{nm: "stat", b: 40'h05_00_00_00_00, n: 3, rx: 40'h00_03_03_00_00, oe: 40'h00_FF_FF_00_00};
`else
    tbl[2] = '{nm: "stat", b: 40'h05_00_00_00_00, n: 3, rx: 40'h0, oe: 40'h0};
`endif
    tbl[3] = '{nm: "cmd9F", b: 40'h9F_00_00_00_00, n: 4, rx: 40'h0, oe: 40'h0};
    tbl[4] = '{nm: "rdFE", b: 40'h03_FE_00_00_00, n: 5, rx: 40'h00_00_11_22_33, oe: 40'h00_00_FF_FF_FF};
    bus.spi_cs_n = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.hst_we = 1'b0;
    bus.hst_addr = '0;
    bus.hst_wdata = '0;
    tick(4);
    chk("rst_miso", {7'd0, bus.spi_miso}, 8'd0);
    chk("rst_oe", {7'd0, bus.spi_miso_oe}, 8'd0);
    chk("rst_rdata", bus.hst_rdata, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    rst_n = 1'b1;
    tick(4);
    chk("idle_busy", {7'd0, bus.busy}, 8'd0);
    for (int a = 0; a < 256; a++) hw(8'(a), 8'($urandom));
    hw(8'h10, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) tx_b[j] = tbl[i].b[j];
      model(tbl[i].n);
      xfer(tbl[i].n);
      for (int j = 0; j < tbl[i].n; j++) begin
        chk({tbl[i].nm, "_miso"}, rx_b[j], tbl[i].rx[j]);
        chk({tbl[i].nm, "_oe"}, oe_b[j], tbl[i].oe[j]);
        chk({tbl[i].nm, "_busy"}, bz_b[j], 8'hFF);
      end
    end
    chkmem("mem_FE", 8'hFE, 8'h11);
    chkmem("mem_FF", 8'hFF, 8'h22);
    chkmem("mem_00", 8'h00, 8'h33);
    chk("after_busy", {7'd0, bus.busy}, 8'd0);
    hw(8'h40, 8'h6C);
    bus.spi_cs_n = 1'b0;
    tick(4);
    sbits(8'h02, 8, r, o, z);
    sbits(8'h40, 8, r, o, z);
    sbits(8'hFF, 5, r, o, z);
    tick(4);
    bus.spi_cs_n = 1'b1;
    tick(8);
    chkmem("partial_keep", 8'h40, 8'h6C);
    tx_b[0] = 8'h03;
    tx_b[1] = 8'h40;
    tx_b[2] = 8'h00;
    run_vec("after_partial", 3);
    collide(8'h20, 8'h5A, 8'h20, 8'hC3);
    chkmem("clash_same", 8'h20, 8'h5A);
    collide(8'h20, 8'h96, 8'h21, 8'hC3);
    chkmem("clash_spi", 8'h20, 8'h96);
    chkmem("clash_hst", 8'h21, 8'hC3);
    bus.spi_cs_n = 1'b0;
    tick(4);
    sbits(8'h03, 8, r, o, z);
    sbits(8'h10, 8, r, o, z);
    chk("mid_oe_before", {7'd0, bus.spi_miso_oe}, 8'd1);
    rst_n = 1'b0;
    tick(2);
    chk("mid_rst_oe", {7'd0, bus.spi_miso_oe}, 8'd0);
    chk("mid_rst_busy", {7'd0, bus.busy}, 8'd0);
    rst_n = 1'b1;
    tick(4);
    for (int j = 0; j < 3; j++) begin
      sbits(j == 0 ? 8'h03 : j == 1 ? 8'h10 : 8'h00, 8, r, o, z);
      chk("held_cs_miso", r, 8'h00);
      chk("held_cs_oe", o, 8'h00);
      chk("held_cs_busy", z, 8'hFF);
    end
    tick(4);
    bus.spi_cs_n = 1'b1;
    tick(8);
    tx_b[0] = 8'h03;
    tx_b[1] = 8'h10;
    tx_b[2] = 8'h00;
    run_vec("after_reset", 3);
    for (int t = 0; t < 30; t++) begin
      k = int'($urandom_range(0, 9));
      tx_b[0] = k < 4 ? 8'h03 : k < 8 ? 8'h02 : k == 8 ? 8'h05 : 8'($urandom);
      n = int'($urandom_range(1, 6));
      for (int j = 1; j < 8; j++) tx_b[j] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) hw(8'($urandom), 8'($urandom));
      run_vec("rand", n);
      k = int'($urandom_range(0, 255));
      chkmem("rand_mem", 8'(k), mm[k]);
      chkmem("rand_wmem", tx_b[1], mm[tx_b[1]]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
